// File: rtl/aes_uart_sender.sv
// aes_uart_sender
// Serialises a 128-bit ciphertext block into a byte stream for a UART
// transmitter. An optional header byte goes first, then the block MSB first.
//
// Ports
//   clk        system clock, all state changes on its rising edge
//   rstn       asynchronous active-low reset
//   baud_tick  one-clk bit-rate strobe, shared with the UART transmitter
//   blk_valid  upstream has a block to hand over
//   blk_data   the 128-bit block, sampled only on the handshake edge
//   blk_ready  sender can take a block (IDLE only)
//   tx_send    byte request to the transmitter (high throughout SEND)
//   tx_data    byte presented to the transmitter
//   tx_busy    transmitter busy flag
//   active     a frame is in progress
//   done       one-clk pulse after the last byte has been handed over
//   state_dbg  current FSM state (IDLE=0, SEND=1, WAIT=2)
//
// Handshake: a block transfers on the rising clk edge where blk_valid and
// blk_ready are both 1. blk_ready is registered, does not depend on
// blk_valid, and stays low from the edge after the handshake until the cycle
// after done, so blk_valid held high during a frame is simply not seen.
module aes_uart_sender #(
  parameter int unsigned HDR_EN   = 1,
  parameter logic [7:0]  HDR_BYTE = 8'hA5
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         baud_tick,
  input  logic         blk_valid,
  input  logic [127:0] blk_data,
  output logic         blk_ready,
  output logic         tx_send,
  output logic [7:0]   tx_data,
  input  logic         tx_busy,
  output logic         active,
  output logic         done,
  output logic [1:0]   state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } state_t;

  // Index of the last byte in a frame: 17 bytes with header, 16 without.
  localparam logic [4:0] LAST_IDX = (HDR_EN != 0) ? 5'd16 : 5'd15;

  state_t         state;
  logic [4:0]     idx;
  logic [127:0]   hold;

  // Byte n of the frame built from block blk. With a header, frame byte 0 is
  // the header and frame byte n is data byte n-1; data byte k is the k-th
  // byte counted from the most significant end.
  function automatic logic [7:0] frame_byte(input logic [127:0] blk,
                                            input logic [4:0]   n);
    logic [4:0] k;
    if (HDR_EN != 0) begin
      if (n == 5'd0) return HDR_BYTE;
      k = n - 5'd1;
    end else begin
      k = n;
    end
    return 8'(blk >> (8'd120 - {k, 3'b000}));
  endfunction

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      blk_ready <= 1'b0;
      tx_send   <= 1'b0;
      tx_data   <= 8'h00;
      active    <= 1'b0;
      done      <= 1'b0;
      idx       <= 5'd0;
      hold      <= 128'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // blk_ready rises one cycle after entering IDLE (after reset or
          // after the done pulse); the handshake is only possible once it
          // is already high.
          if (!blk_ready) begin
            blk_ready <= 1'b1;
          end else if (blk_valid) begin
            hold      <= blk_data;
            idx       <= 5'd0;
            tx_data   <= frame_byte(blk_data, 5'd0);
            blk_ready <= 1'b0;
            tx_send   <= 1'b1;
            active    <= 1'b1;
            state     <= SEND;
          end
        end
        SEND: begin
          // tx_send is held through a baud_tick so the transmitter, which
          // only looks at tx_send on a tick, is guaranteed to see it.
          if (baud_tick) begin
            tx_send <= 1'b0;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (!tx_busy) begin
            if (idx == LAST_IDX) begin
              active <= 1'b0;
              done   <= 1'b1;
              state  <= IDLE;
            end else begin
              idx     <= idx + 5'd1;
              tx_data <= frame_byte(hold, idx + 5'd1);
              tx_send <= 1'b1;
              state   <= SEND;
            end
          end
        end
        default: begin
          tx_send <= 1'b0;
          active  <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_aes_uart_sender.sv
// Testbench for aes_uart_sender. Two instances share clock, reset and
// baud_tick: unit 0 sends a header (HDR_EN=1), unit 1 does not (HDR_EN=0).
// A behavioural UART transmitter per unit accepts a byte when it is idle and
// sees tx_send on a baud tick, then stays busy for 10 ticks (start, 8 data,
// stop). Accepted bytes are compared with frames built from the block.
`timescale 1ns/1ps
module tb_aes_uart_sender;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstn = 1'b0;

  // baud strobe: periodic divider, or manual pulses for tick-alignment cases
  logic baud_tick;
  logic per_tick = 1'b0;
  logic man_tick = 1'b0;
  logic man_mode = 1'b0;
  int   baud_div = 16;
  int   baud_cnt = 0;
  assign baud_tick = man_mode ? man_tick : per_tick;

  always @(negedge clk) begin
    if (baud_cnt >= baud_div - 1) begin
      baud_cnt = 0;
      per_tick = 1'b1;
    end else begin
      baud_cnt = baud_cnt + 1;
      per_tick = 1'b0;
    end
  end

  // ---------------- DUT signals (index = unit) ----------------
  logic         blk_valid [2];
  logic [127:0] blk_data  [2];
  logic         blk_ready [2];
  logic         tx_send   [2];
  logic [7:0]   tx_data   [2];
  logic         tx_busy   [2];
  logic         active    [2];
  logic         done      [2];
  logic [1:0]   state_dbg [2];

  logic stub_en   = 1'b0;
  logic stub_busy = 1'b0;
  logic m_busy [2] = '{1'b0, 1'b0};
  int   m_ticks[2] = '{0, 0};

  assign tx_busy[0] = stub_en ? stub_busy : m_busy[0];
  assign tx_busy[1] = m_busy[1];

  aes_uart_sender #(.HDR_EN(1), .HDR_BYTE(8'hA5)) dut_hdr (
    .clk(clk), .rstn(rstn), .baud_tick(baud_tick),
    .blk_valid(blk_valid[0]), .blk_data(blk_data[0]), .blk_ready(blk_ready[0]),
    .tx_send(tx_send[0]), .tx_data(tx_data[0]), .tx_busy(tx_busy[0]),
    .active(active[0]), .done(done[0]), .state_dbg(state_dbg[0])
  );

  aes_uart_sender #(.HDR_EN(0), .HDR_BYTE(8'hA5)) dut_raw (
    .clk(clk), .rstn(rstn), .baud_tick(baud_tick),
    .blk_valid(blk_valid[1]), .blk_data(blk_data[1]), .blk_ready(blk_ready[1]),
    .tx_send(tx_send[1]), .tx_data(tx_data[1]), .tx_busy(tx_busy[1]),
    .active(active[1]), .done(done[1]), .state_dbg(state_dbg[1])
  );

  // ---------------- behavioural transmitters ----------------
  logic [7:0] got0[$];
  logic [7:0] got1[$];

  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (baud_tick) begin
        if (m_busy[u]) begin
          if (m_ticks[u] == 9) m_busy[u] <= 1'b0;
          else m_ticks[u] <= m_ticks[u] + 1;
        end else if (tx_send[u]) begin
          m_busy[u]  <= 1'b1;
          m_ticks[u] <= 0;
          if (u == 0) got0.push_back(tx_data[u]);
          else got1.push_back(tx_data[u]);
        end
      end
    end
  end

  // ---------------- protocol monitors ----------------
  int   done_cnt[2] = '{0, 0};
  logic done_q  [2] = '{1'b0, 1'b0};
  int   ready_viol = 0;
  int   done_viol  = 0;

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (done[u]) done_cnt[u] = done_cnt[u] + 1;
      if (done[u] && done_q[u]) done_viol = done_viol + 1;
      if (blk_ready[u] && active[u]) ready_viol = ready_viol + 1;
      done_q[u] = done[u];
    end
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Expected frame: optional header, then the 16 block bytes from the top.
  task automatic push_frame(input int u, input logic [127:0] blk);
    if (u == 0) exp_q.push_back(8'hA5);
    for (int k = 0; k < 16; k++) exp_q.push_back(8'((blk >> (120 - 8 * k)) & 128'hFF));
  endtask

  task automatic compare_bytes(input int u, input string name);
    logic [7:0] got[$];
    if (u == 0) got = got0;
    else got = got1;
    check({name, " byte count"}, 128'(got.size()), 128'(exp_q.size()));
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      check($sformatf("%s byte %0d", name, i), 128'(got[i]), 128'(exp_q[i]));
    got0.delete();
    got1.delete();
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  // Returns at the negedge just after the handshake edge (first SEND cycle).
  task automatic send_block(input int u, input logic [127:0] blk, input string name);
    int c;
    @(negedge clk);
    blk_valid[u] = 1'b1;
    blk_data[u]  = blk;
    c = 0;
    while (!blk_ready[u] && c < 200) begin
      @(negedge clk);
      c++;
    end
    if (!blk_ready[u]) timeout_fail({name, " handshake"});
    @(negedge clk);
    blk_valid[u] = 1'b0;
    blk_data[u]  = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  task automatic wait_done(input int u, input string name);
    int c;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!done[u] && c < 8000);
    if (!done[u]) timeout_fail({name, " done"});
  endtask

  // Full frame with end-of-frame checks.
  task automatic run_frame(input int u, input logic [127:0] blk, input string name);
    int d0;
    d0 = done_cnt[u];
    push_frame(u, blk);
    send_block(u, blk, name);
    wait_done(u, name);
    @(negedge clk);
    check({name, " done pulses"}, 128'(done_cnt[u] - d0), 128'd1);
    check({name, " active after"}, 128'(active[u]), 128'd0);
    compare_bytes(u, name);
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    int           unit;
    logic [127:0] blk;
    int           div;
    int           exp_len;
    logic [7:0]   exp_first;
    logic [7:0]   exp_last;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [127:0] a_blk, b_blk, r_blk;
    logic [7:0]   held;
    int           c, viol, d0, u;

    blk_valid = '{1'b0, 1'b0};
    blk_data  = '{128'd0, 128'd0};

    vecs[0] = '{0, 128'h00112233445566778899AABBCCDDEEFF, 16, 17, 8'hA5, 8'hFF};
    vecs[1] = '{1, {128{1'b1}},                          16, 16, 8'hFF, 8'hFF};
    vecs[2] = '{0, 128'd0,                                8, 17, 8'hA5, 8'h00};
    vecs[3] = '{1, 128'h0102030405060708090A0B0C0D0E0F10, 5, 16, 8'h01, 8'h10};

    // reset state
    repeat (3) @(negedge clk);
    check("reset blk_ready", 128'(blk_ready[0]), 128'd0);
    check("reset tx_send",   128'(tx_send[0]),   128'd0);
    check("reset tx_data",   128'(tx_data[0]),   128'd0);
    check("reset active",    128'(active[0]),    128'd0);
    check("reset done",      128'(done[0]),      128'd0);
    check("reset state",     128'(state_dbg[0]), 128'd0);
    check("reset raw ready", 128'(blk_ready[1]), 128'd0);
    rstn = 1'b1;
    @(negedge clk);
    check("ready after release", 128'(blk_ready[0]), 128'd1);

    // table-driven frames
    for (int i = 0; i < 4; i++) begin
      baud_div = vecs[i].div;
      if (vecs[i].unit == 0) begin
        // scoreboard is filled by run_frame; look at the queue first
        check($sformatf("vec%0d len", i), 128'(vecs[i].exp_len), 128'd17);
      end
      u = vecs[i].unit;
      push_frame(u, vecs[i].blk);
      check($sformatf("vec%0d model len", i), 128'(exp_q.size()), 128'(vecs[i].exp_len));
      exp_q.delete();
      d0 = done_cnt[u];
      push_frame(u, vecs[i].blk);
      send_block(u, vecs[i].blk, $sformatf("vec%0d", i));
      wait_done(u, $sformatf("vec%0d", i));
      @(negedge clk);
      check($sformatf("vec%0d done pulses", i), 128'(done_cnt[u] - d0), 128'd1);
      check($sformatf("vec%0d active after", i), 128'(active[u]), 128'd0);
      if (u == 0) begin
        if (got0.size() > 0) begin
          check($sformatf("vec%0d first", i), 128'(got0[0]), 128'(vecs[i].exp_first));
          check($sformatf("vec%0d last", i), 128'(got0[got0.size()-1]), 128'(vecs[i].exp_last));
        end else timeout_fail($sformatf("vec%0d no bytes", i));
      end else begin
        if (got1.size() > 0) begin
          check($sformatf("vec%0d first", i), 128'(got1[0]), 128'(vecs[i].exp_first));
          check($sformatf("vec%0d last", i), 128'(got1[got1.size()-1]), 128'(vecs[i].exp_last));
        end else timeout_fail($sformatf("vec%0d no bytes", i));
      end
      compare_bytes(u, $sformatf("vec%0d", i));
    end
    baud_div = 16;

    // tick coincident with the first SEND cycle: tx_send high one cycle only
    man_mode = 1'b1;
    man_tick = 1'b0;
    a_blk = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    push_frame(0, a_blk);
    d0 = done_cnt[0];
    send_block(0, a_blk, "early tick");
    check("early tick send high", 128'(tx_send[0]), 128'd1);
    man_tick = 1'b1;
    @(negedge clk);
    man_tick = 1'b0;
    check("early tick send low", 128'(tx_send[0]), 128'd0);
    check("early tick in WAIT", 128'(state_dbg[0]), 128'd2);
    man_mode = 1'b0;
    wait_done(0, "early tick");
    @(negedge clk);
    check("early tick done pulses", 128'(done_cnt[0] - d0), 128'd1);
    compare_bytes(0, "early tick");

    // back-to-back blocks with blk_valid held high
    a_blk = {$urandom(), $urandom(), $urandom(), $urandom()};
    b_blk = ~a_blk ^ 128'h5A;
    push_frame(0, a_blk);
    push_frame(0, b_blk);
    d0 = done_cnt[0];
    viol = ready_viol;
    send_block(0, a_blk, "b2b first");
    blk_valid[0] = 1'b1;       // keep offering the second block
    blk_data[0]  = b_blk;
    wait_done(0, "b2b first");
    @(negedge clk);
    check("b2b ready after done", 128'(blk_ready[0]), 128'd1);
    @(negedge clk);            // second handshake happened on that edge
    blk_valid[0] = 1'b0;
    check("b2b second captured", 128'(active[0]), 128'd1);
    wait_done(0, "b2b second");
    @(negedge clk);
    check("b2b done pulses", 128'(done_cnt[0] - d0), 128'd2);
    check("b2b ready in frame", 128'(ready_viol - viol), 128'd0);
    compare_bytes(0, "b2b");

    // reset in the middle of byte 5
    r_blk = {$urandom(), $urandom(), $urandom(), $urandom()};
    d0 = done_cnt[0];
    send_block(0, r_blk, "mid reset");
    c = 0;
    while (got0.size() < 5 && c < 4000) begin
      @(negedge clk);
      c++;
    end
    if (got0.size() < 5) timeout_fail("mid reset reach byte 5");
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check("mid reset tx_send", 128'(tx_send[0]), 128'd0);
    check("mid reset active",  128'(active[0]),  128'd0);
    check("mid reset ready",   128'(blk_ready[0]), 128'd0);
    check("mid reset tx_data", 128'(tx_data[0]), 128'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("mid reset ready back", 128'(blk_ready[0]), 128'd1);
    repeat (400) @(negedge clk);
    check("mid reset no more bytes", 128'(got0.size()), 128'd5);
    check("mid reset no done", 128'(done_cnt[0] - d0), 128'd0);
    got0.delete();
    exp_q.delete();
    run_frame(0, ~r_blk, "after reset");

    // transmitter held busy for 1000 clk while the sender waits
    stub_en   = 1'b1;
    stub_busy = 1'b1;
    a_blk = {$urandom(), $urandom(), $urandom(), $urandom()};
    push_frame(0, a_blk);
    d0 = done_cnt[0];
    send_block(0, a_blk, "stall");
    c = 0;
    while (state_dbg[0] != 2'd2 && c < 200) begin
      @(negedge clk);
      c++;
    end
    if (state_dbg[0] != 2'd2) timeout_fail("stall reach WAIT");
    held = tx_data[0];
    check("stall held header", 128'(held), 128'hA5);
    viol = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (state_dbg[0] != 2'd2 || tx_send[0] || tx_data[0] != held) viol++;
    end
    check("stall stays in WAIT", 128'(viol), 128'd0);
    stub_busy = 1'b0;
    stub_en   = 1'b0;
    @(negedge clk);
    check("stall resumes SEND", 128'(state_dbg[0]), 128'd1);
    check("stall resume send",  128'(tx_send[0]),   128'd1);
    check("stall next byte",    128'(tx_data[0]),   128'(a_blk[127:120]));
    wait_done(0, "stall");
    @(negedge clk);
    check("stall done pulses", 128'(done_cnt[0] - d0), 128'd1);
    compare_bytes(0, "stall");

    // randomized frames on both units
    for (int i = 0; i < 6; i++) begin
      u = int'($urandom_range(0, 1));
      baud_div = int'($urandom_range(2, 20));
      r_blk = {$urandom(), $urandom(), $urandom(), $urandom()};
      run_frame(u, r_blk, $sformatf("rand%0d u%0d", i, u));
    end

    check("done single-cycle", 128'(done_viol), 128'd0);
    check("ready only when idle", 128'(ready_viol), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
